// File: rtl/bp_pkg.sv
// Shared types for branch recovery: FSM encoding, tag widths, BTAP update
// record, and the age comparison used by lane arbitration and preemption.
package bp_pkg;
  localparam int TAG_W  = 4;
  localparam int BTAG_W = 5;
  localparam int ADDR_W = 32;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } rec_state_e;

  typedef struct packed {
    logic [BTAG_W-1:0] tag;
    logic [ADDR_W-1:0] addr;
  } btap_upd_t;

  // Age is distance from the ROB head modulo 16; smaller distance is older.
  function automatic logic older(input tag_t a, input tag_t b, input tag_t head);
    tag_t age_a;
    tag_t age_b;
    age_a = a - head;
    age_b = b - head;
    return age_a < age_b;
  endfunction
endpackage

// File: rtl/btap_upd_fifo.sv
// BTAP update queue: FIFO of accepted branch target updates. A push on a full
// queue is discarded unless the head is leaving in the same cycle.
module btap_upd_fifo
  import bp_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  btap_upd_t din,
  input  logic      ready,
  output logic      we,
  output btap_upd_t dout,
  output logic      drop
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  btap_upd_t     mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          empty, full, pop, accept;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty  = (cnt == '0);
    full   = (cnt == (PW+1)'(QDEPTH));
    pop    = !empty && ready;
    accept = push && (!full || pop);
    we     = !empty;
    dout   = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= push && full && !pop;
      if (accept) wr_ptr <= bump(wr_ptr);
      if (pop)    rd_ptr <= bump(rd_ptr);
      cnt <= cnt + (PW+1)'(accept) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/branch_recovery_ctrl.sv
// Two-lane branch mispredict recovery: picks the oldest mispredict, pulses a
// fetch redirect, holds flush for FLUSH_CYCLES, and queues BTAP updates.
module branch_recovery_ctrl
  import bp_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int QDEPTH       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex0_valid,
  input  logic              ex0_pcsrc,
  input  tag_t              ex0_tag,
  input  logic [ADDR_W-1:0] ex0_pcbranch,
  input  logic [BTAG_W-1:0] ex0_btaptag,
  input  logic [ADDR_W-1:0] ex0_btapaddr,
  input  logic              ex1_valid,
  input  logic              ex1_pcsrc,
  input  tag_t              ex1_tag,
  input  logic [ADDR_W-1:0] ex1_pcbranch,
  input  logic [BTAG_W-1:0] ex1_btaptag,
  input  logic [ADDR_W-1:0] ex1_btapaddr,
  input  tag_t              head_tag,
  input  logic              btap_ready,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output tag_t              flush_tag,
  output logic              stall_fetch,
  output logic              btap_we,
  output logic [BTAG_W-1:0] btap_wtag,
  output logic [ADDR_W-1:0] btap_waddr,
  output logic              btap_drop
);
  rec_state_e        state, state_nx;
  logic [2:0]        fcnt, fcnt_nx;
  logic              c0, c1, pick1, accept;
  tag_t              win_tag;
  logic [ADDR_W-1:0] win_pc;
  btap_upd_t         win_upd, head_upd;

  always_comb begin
    c0      = ex0_valid && ex0_pcsrc;
    c1      = ex1_valid && ex1_pcsrc;
    // lane 1 only wins a tie-free age race; equal age stays with lane 0
    pick1   = c1 && (!c0 || older(ex1_tag, ex0_tag, head_tag));
    win_tag = pick1 ? ex1_tag : ex0_tag;
    win_pc  = pick1 ? ex1_pcbranch : ex0_pcbranch;
    win_upd = pick1 ? '{tag: ex1_btaptag, addr: ex1_btapaddr}
                    : '{tag: ex0_btaptag, addr: ex0_btapaddr};
    accept  = (c0 || c1) && (state == IDLE || older(win_tag, flush_tag, head_tag));
  end

  always_comb begin
    state_nx    = state;
    fcnt_nx     = fcnt;
    redirect    = 1'b0;
    flush       = 1'b0;
    stall_fetch = 1'b0;
    case (state)
      IDLE: ;
      REDIRECT: begin
        redirect    = 1'b1;
        stall_fetch = 1'b1;
        state_nx    = FLUSH;
        fcnt_nx     = 3'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        flush       = 1'b1;
        stall_fetch = 1'b1;
        if (fcnt == '0) state_nx = IDLE;
        else            fcnt_nx  = fcnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (accept) state_nx = REDIRECT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fcnt        <= '0;
      flush_tag   <= '0;
      redirect_pc <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      if (accept) begin
        flush_tag   <= win_tag;
        redirect_pc <= win_pc;
      end
    end
  end

  btap_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (win_upd),
    .ready (btap_ready),
    .we    (btap_we),
    .dout  (head_upd),
    .drop  (btap_drop)
  );

  assign btap_wtag  = head_upd.tag;
  assign btap_waddr = head_upd.addr;
endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Randomized bench for branch_recovery_ctrl: a recovery/queue reference model
// feeds scoreboards that a negedge monitor drains against DUT outputs.
module tb_branch_recovery_ctrl;
  localparam int F  = 2;
  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex0_valid, ex0_pcsrc, ex1_valid, ex1_pcsrc;
  logic [3:0]  ex0_tag, ex1_tag, head_tag;
  logic [31:0] ex0_pcbranch, ex1_pcbranch, ex0_btapaddr, ex1_btapaddr;
  logic [4:0]  ex0_btaptag, ex1_btaptag;
  logic        btap_ready;
  logic        redirect, flush, stall_fetch, btap_we, btap_drop;
  logic [31:0] redirect_pc, btap_waddr;
  logic [3:0]  flush_tag;
  logic [4:0]  btap_wtag;

  branch_recovery_ctrl #(.FLUSH_CYCLES(F), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .ex0_valid(ex0_valid), .ex0_pcsrc(ex0_pcsrc), .ex0_tag(ex0_tag),
    .ex0_pcbranch(ex0_pcbranch), .ex0_btaptag(ex0_btaptag), .ex0_btapaddr(ex0_btapaddr),
    .ex1_valid(ex1_valid), .ex1_pcsrc(ex1_pcsrc), .ex1_tag(ex1_tag),
    .ex1_pcbranch(ex1_pcbranch), .ex1_btaptag(ex1_btaptag), .ex1_btapaddr(ex1_btapaddr),
    .head_tag(head_tag), .btap_ready(btap_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .flush_tag(flush_tag),
    .stall_fetch(stall_fetch), .btap_we(btap_we), .btap_wtag(btap_wtag),
    .btap_waddr(btap_waddr), .btap_drop(btap_drop)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] t; logic [31:0] a; } upd_s;
  typedef struct { logic [31:0] pc; logic [3:0] tag; } rd_s;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since last redirect (0 = redirect cycle,
  // 1..F = flush, >F = idle), the recovering branch, and the update queue.
  int          m_since = F + 1;
  logic [3:0]  m_tag = '0;
  logic [31:0] m_pc = '0;
  bit          m_drop = 0;
  bit          m_rst_last = 0;
  upd_s        mq[$];
  upd_s        exp_wr[$];
  rd_s         exp_rd[$];

  int          a0, a1, ar, wa, w;
  upd_s        we_e;
  logic [3:0]  wt;
  logic [31:0] wpc;

  always @(posedge clk) begin
    m_rst_last = reset;
    if (reset) begin
      m_since = F + 1; m_tag = '0; m_pc = '0; m_drop = 0;
      mq.delete(); exp_wr.delete(); exp_rd.delete();
    end else begin
      a0 = (int'(ex0_tag) - int'(head_tag) + 16) % 16;
      a1 = (int'(ex1_tag) - int'(head_tag) + 16) % 16;
      ar = (int'(m_tag) - int'(head_tag) + 16) % 16;
      w = -1;
      if (ex0_valid && ex0_pcsrc && ex1_valid && ex1_pcsrc) w = (a1 < a0) ? 1 : 0;
      else if (ex0_valid && ex0_pcsrc) w = 0;
      else if (ex1_valid && ex1_pcsrc) w = 1;
      wa = (w == 1) ? a1 : a0;
      if (btap_ready && mq.size() > 0) void'(mq.pop_front());
      m_drop = 0;
      if (w >= 0 && (m_since > F || wa < ar)) begin
        we_e.t = (w == 1) ? ex1_btaptag : ex0_btaptag;
        we_e.a = (w == 1) ? ex1_btapaddr : ex0_btapaddr;
        wt     = (w == 1) ? ex1_tag : ex0_tag;
        wpc    = (w == 1) ? ex1_pcbranch : ex0_pcbranch;
        if (mq.size() < QD) begin
          mq.push_back(we_e);
          exp_wr.push_back(we_e);
        end else m_drop = 1;
        m_since = 0; m_tag = wt; m_pc = wpc;
        exp_rd.push_back('{pc: wpc, tag: wt});
      end else if (m_since <= F) m_since++;
    end
  end

  rd_s  got_rd;
  upd_s got_wr;

  always @(negedge clk) begin
    if (started) begin
      chk("redirect", redirect, m_since == 0);
      chk("flush", flush, m_since >= 1 && m_since <= F);
      chk("stall_fetch", stall_fetch, m_since <= F);
      chk("flush_tag", flush_tag, m_tag);
      chk("redirect_pc", redirect_pc, m_pc);
      chk("btap_we", btap_we, mq.size() > 0);
      chk("btap_drop", btap_drop, m_drop);
      if (m_rst_last) begin
        chk("rst_wtag", btap_wtag, 0);
        chk("rst_waddr", btap_waddr, 0);
      end
      if (redirect) begin
        if (exp_rd.size() == 0) chk("redirect_unexpected", 1, 0);
        else begin
          got_rd = exp_rd.pop_front();
          chk("sb_redirect_pc", redirect_pc, got_rd.pc);
          chk("sb_flush_tag", flush_tag, got_rd.tag);
        end
      end
      if (btap_we && btap_ready) begin
        if (exp_wr.size() == 0) chk("btap_write_unexpected", 1, 0);
        else begin
          got_wr = exp_wr.pop_front();
          chk("sb_btap_wtag", btap_wtag, got_wr.t);
          chk("sb_btap_waddr", btap_waddr, got_wr.a);
        end
      end
    end
  end

  task automatic clr();
    ex0_valid = 0; ex0_pcsrc = 0; ex1_valid = 0; ex1_pcsrc = 0;
  endtask

  task automatic lane(input int l, input logic [3:0] t, input logic [31:0] pc);
    if (l == 0) begin
      ex0_valid = 1; ex0_pcsrc = 1; ex0_tag = t; ex0_pcbranch = pc;
      ex0_btaptag = 5'($urandom); ex0_btapaddr = $urandom;
    end else begin
      ex1_valid = 1; ex1_pcsrc = 1; ex1_tag = t; ex1_pcbranch = pc;
      ex1_btaptag = 5'($urandom); ex1_btapaddr = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; clr();
  endtask

  initial begin
    clr();
    ex0_tag = 0; ex1_tag = 0; ex0_pcbranch = 0; ex1_pcbranch = 0;
    ex0_btaptag = 0; ex1_btaptag = 0; ex0_btapaddr = 0; ex1_btapaddr = 0;
    head_tag = 0; btap_ready = 1; reset = 1;
    @(posedge clk); #1; started = 1;
    tick(); reset = 0;

    // single mispredict on lane 1
    lane(1, 4'd3, 32'h40); tick(); repeat (5) tick();
    // wrapped ages: tag 15 (age 1) beats tag 1 (age 3) with head 14
    head_tag = 14; lane(0, 4'd1, 32'h100); lane(1, 4'd15, 32'h200); tick(); repeat (5) tick();
    // equal tags on both lanes: lane 0 wins
    head_tag = 0; lane(0, 4'd6, 32'h600); lane(1, 4'd6, 32'h660); tick(); repeat (5) tick();
    // preemption by older branch during flush; younger one ignored
    lane(0, 4'd5, 32'h500); tick(); tick();
    lane(0, 4'd2, 32'h222); tick();
    lane(1, 4'd7, 32'h777); tick(); repeat (5) tick();
    // queue full with writes stalled: third update dropped
    btap_ready = 0;
    lane(0, 4'd1, 32'h1000); tick(); repeat (4) tick();
    lane(1, 4'd2, 32'h2000); tick(); repeat (4) tick();
    lane(0, 4'd3, 32'h3000); tick(); repeat (4) tick();
    btap_ready = 1; repeat (4) tick();
    // reset in the middle of flush with a pending update and live inputs
    btap_ready = 0;
    lane(0, 4'd3, 32'h3300); tick(); tick();
    reset = 1; lane(1, 4'd1, 32'h1111); tick();
    reset = 0; tick(); btap_ready = 1; repeat (3) tick();

    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) lane(0, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) lane(1, 4'($urandom), $urandom);
      if ($urandom_range(0, 7) == 0) begin ex0_valid = 1; ex0_pcsrc = 0; end
      if ($urandom_range(0, 15) == 0) head_tag = 4'($urandom);
      btap_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    reset = 0; btap_ready = 1;
    repeat (10) tick();
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_recovery_ctrl.md
BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: cycles flush is held after redirect (1..7).
REQ-002 SHALL have parameter QDEPTH, default 2: BTAP update queue depth (power of 2).
REQ-003 SHALL have port clk, in, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, in, 1: synchronous, active-high.
REQ-005 SHALL have ports ex0_valid/ex1_valid, in, 1: lane result valid this cycle.
REQ-006 SHALL have ports ex0_pcsrc/ex1_pcsrc, in, 1: lane branch mispredicted.
REQ-007 SHALL have ports ex0_tag/ex1_tag, in, 4: lane instruction age tag.
REQ-008 SHALL have ports ex0_pcbranch/ex1_pcbranch, in, 32: lane corrected next PC.
REQ-009 SHALL have ports ex0_btaptag/ex1_btaptag, in, 5: lane BTAP index.
REQ-010 SHALL have ports ex0_btapaddr/ex1_btapaddr, in, 32: lane BTAP target.
REQ-011 SHALL have port head_tag, in, 4: tag of oldest in-flight instruction.
REQ-012 SHALL have port btap_ready, in, 1: BTAP write port accepts this cycle.
REQ-013 SHALL have port redirect, out, 1: one-cycle fetch redirect pulse.
REQ-014 SHALL have port redirect_pc, out, 32: redirect target, valid with redirect.
REQ-015 SHALL have port flush, out, 1: squash instructions younger than flush_tag.
REQ-016 SHALL have port flush_tag, out, 4: tag of the recovering branch.
REQ-017 SHALL have port stall_fetch, out, 1: fetch held (redirect or flush active).
REQ-018 SHALL have ports btap_we (1), btap_wtag (5), btap_waddr (32), out: BTAP write request.
REQ-019 SHALL have port btap_drop, out, 1: one-cycle pulse, update discarded on full queue.

Function
REQ-020 Age SHALL be (tag - head_tag) mod 16, 4-bit unsigned; smaller is older.
REQ-021 A lane is a candidate when valid & pcsrc; with two candidates the older wins, equal age picks lane 0.
REQ-022 FSM states SHALL be IDLE, REDIRECT, FLUSH.
REQ-023 IDLE with a candidate in cycle N: REDIRECT in N+1; redirect=1, redirect_pc=winner pcbranch, flush_tag=winner tag.
REQ-024 REDIRECT SHALL last exactly one cycle, then FLUSH with flush=1 for FLUSH_CYCLES cycles, then IDLE.
REQ-025 stall_fetch SHALL be 1 in REDIRECT and FLUSH, else 0; flush SHALL be 0 in IDLE and REDIRECT.
REQ-026 In REDIRECT/FLUSH, a candidate strictly older than flush_tag (age compare per REQ-020) SHALL restart REDIRECT next cycle with its PC/tag; younger or equal candidates SHALL be ignored.
REQ-027 Each accepted winner (REQ-023/026) SHALL enqueue {btaptag, btapaddr}; losing and ignored candidates SHALL NOT.
REQ-028 Queue head SHALL drive btap_we=1 with btap_wtag/btap_waddr while non-empty; pop when btap_we & btap_ready.
REQ-029 Enqueue on full with no same-cycle pop SHALL discard the new entry and pulse btap_drop next cycle; enqueue with same-cycle pop on full SHALL succeed.
REQ-030 Queue pointers SHALL wrap modulo QDEPTH; order SHALL be FIFO.
REQ-031 redirect_pc and flush_tag SHALL hold their last value outside REDIRECT.

Reset
REQ-032 reset SHALL force IDLE, empty queue, and all outputs to 0 (redirect_pc=0, flush_tag=0) next cycle.
REQ-033 reset mid-REDIRECT/FLUSH SHALL abort recovery and drop queued updates; inputs during reset SHALL be ignored.

Structure
REQ-034 FSM state encodings and the tag width (4) SHALL live in shared package bp_pkg.
REQ-035 The update queue SHALL be one sub-module, btap_upd_fifo; age comparison SHALL be a function in bp_pkg.

Verification
REQ-036 head_tag=0, ex1 mispredict tag=3 pcbranch=0x40: redirect cycle N+1 pc=0x40, flush 2 cycles, btap_we with queued entry.
REQ-037 head_tag=14, ex0 tag=1, ex1 tag=15 both mispredict: ex1 wins (age 1 vs 3), flush_tag=15.
REQ-038 During FLUSH of tag 5 (head 0), tag 2 mispredicts: redirect restarts to its PC; tag 7 mispredict ignored, nothing enqueued.
REQ-039 btap_ready=0, three accepted mispredicts: third dropped, btap_drop pulses; raise ready: two writes in FIFO order.
REQ-040 reset asserted in FLUSH: next cycle all outputs 0, queue empty, btap_we=0.
